alu_op_cell: RTL and testbench

ALU_OP_CELL -- requirements
Module: alu_op_cell

---
 rtl/alu_op_cell.sv | 107 ++++++++++
 tb/tb_alu_op_cell.sv | 134 +++++++++++++
 2 files changed

// File: rtl/alu_op_cell.sv
// rtl/alu_op_cell.sv - two-operand collector cell feeding an external combinational operator
//
// Collects two operand words from a valid-only input stream into registers
// A and B, presents them to an external operator, and offers that operator's
// result downstream. While a result is pending, a new input word chains the
// previous result into A so expression trees can be reduced left-to-right.
//
// Ports:
//   i_clk           clock, all state updates on the rising edge
//   i_rst           synchronous active-high reset
//   i_data_valid    i_data carries an operand this cycle (always accepted)
//   i_data          operand word
//   i_result_ready  downstream consumes the result this cycle
//   o_result_valid  both operands held, o_result meaningful
//   o_result        operator result while FULL, zero otherwise
//   o_op_a          first operand to the external operator (register A)
//   o_op_b          second operand to the external operator (register B)
//   i_op_result     combinational operator output for o_op_a/o_op_b

module alu_op_cell #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_data_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_result_ready,
  output logic             o_result_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  input  logic [WIDTH-1:0] i_op_result
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= EMPTY;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    case (state)
      EMPTY: begin
        if (i_data_valid) begin
          a_nxt     = i_data;
          state_nxt = HALF;
        end
      end
      HALF: begin
        if (i_data_valid) begin
          b_nxt     = i_data;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (i_result_ready && i_data_valid) begin
          // Result leaves this cycle; the new word starts a fresh pair.
          a_nxt     = i_data;
          b_nxt     = '0;
          state_nxt = HALF;
        end else if (i_result_ready) begin
          a_nxt     = '0;
          b_nxt     = '0;
          state_nxt = EMPTY;
        end else if (i_data_valid) begin
          // Chaining: the unconsumed result becomes the next left operand.
          a_nxt     = i_op_result;
          b_nxt     = i_data;
          state_nxt = FULL;
        end
      end
      default: begin
        a_nxt     = '0;
        b_nxt     = '0;
        state_nxt = EMPTY;
      end
    endcase
  end

  assign o_op_a         = a_q;
  assign o_op_b         = b_q;
  assign o_result_valid = (state == FULL);
  assign o_result       = (state == FULL) ? i_op_result : '0;

endmodule

// File: tb/tb_alu_op_cell.sv
// tb/tb_alu_op_cell.sv - directed self-checking bench for alu_op_cell with a bitwise-AND operator

module tb_alu_op_cell;

  localparam int WIDTH = 32;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_data_valid = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_result_ready = 1'b0;
  logic             o_result_valid;
  logic [WIDTH-1:0] o_result;
  logic [WIDTH-1:0] o_op_a;
  logic [WIDTH-1:0] o_op_b;
  logic [WIDTH-1:0] i_op_result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_cell #(.WIDTH(WIDTH)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_data_valid   (i_data_valid),
    .i_data         (i_data),
    .i_result_ready (i_result_ready),
    .o_result_valid (o_result_valid),
    .o_result       (o_result),
    .o_op_a         (o_op_a),
    .o_op_b         (o_op_b),
    .i_op_result    (i_op_result)
  );

  assign i_op_result = o_op_a & o_op_b;

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic dv, input logic [WIDTH-1:0] d, input logic rdy);
    i_rst          = rst;
    i_data_valid   = dv;
    i_data         = d;
    i_result_ready = rdy;
    @(posedge i_clk);
    #1;
    i_rst          = 1'b0;
    i_data_valid   = 1'b0;
    i_data         = '0;
    i_result_ready = 1'b0;
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [WIDTH-1:0] r,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    check({tag, ".valid"},  {{(WIDTH-1){1'b0}}, o_result_valid}, {{(WIDTH-1){1'b0}}, v});
    check({tag, ".result"}, o_result, r);
    check({tag, ".op_a"},   o_op_a, a);
    check({tag, ".op_b"},   o_op_b, b);
  endtask

  initial begin
    // Reset state, even with data offered during reset.
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    expect_all("reset", 1'b0, 32'h0, 32'h0, 32'h0);

    // Basic pair: 0x1B & 0x0E = 0x0A.
    step(1'b0, 1'b1, 32'h1B, 1'b0);
    expect_all("half1", 1'b0, 32'h0, 32'h1B, 32'h0);
    step(1'b0, 1'b1, 32'h0E, 1'b0);
    expect_all("full1", 1'b1, 32'h0A, 32'h1B, 32'h0E);

    // Idle cycle holds.
    step(1'b0, 1'b0, 32'h0, 1'b0);
    expect_all("hold_full", 1'b1, 32'h0A, 32'h1B, 32'h0E);

    // Consume -> EMPTY, registers cleared.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_all("consume", 1'b0, 32'h0, 32'h0, 32'h0);

    // Chaining: 0x3F, 0x38, 0x18.
    step(1'b0, 1'b1, 32'h3F, 1'b0);
    step(1'b0, 1'b1, 32'h38, 1'b0);
    expect_all("chain_pair", 1'b1, 32'h38, 32'h3F, 32'h38);
    step(1'b0, 1'b1, 32'h18, 1'b0);
    expect_all("chain", 1'b1, 32'h18, 32'h38, 32'h18);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_all("chain_consume", 1'b0, 32'h0, 32'h0, 32'h0);

    // Consume and load in the same edge -> HALF with new A.
    step(1'b0, 1'b1, 32'h0F, 1'b0);
    step(1'b0, 1'b1, 32'h0C, 1'b0);
    expect_all("pre_swap", 1'b1, 32'h0C, 32'h0F, 32'h0C);
    step(1'b0, 1'b1, 32'h05, 1'b1);
    expect_all("swap", 1'b0, 32'h0, 32'h05, 32'h0);
    step(1'b0, 1'b1, 32'h07, 1'b0);
    expect_all("swap_full", 1'b1, 32'h05, 32'h05, 32'h07);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Ready ignored in EMPTY and HALF.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_all("rdy_empty", 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'hA5A5_F00F, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    expect_all("rdy_half", 1'b0, 32'h0, 32'hA5A5_F00F, 32'h0);

    // Full-width operands, no truncation.
    step(1'b0, 1'b1, 32'hFF00_FF0F, 1'b0);
    expect_all("wide", 1'b1, 32'hA500_F00F, 32'hA5A5_F00F, 32'hFF00_FF0F);

    // Reset while FULL with data offered.
    step(1'b1, 1'b1, 32'h1234_5678, 1'b0);
    expect_all("rst_full", 1'b0, 32'h0, 32'h0, 32'h0);

    // Reset while HALF.
    step(1'b0, 1'b1, 32'h77, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    expect_all("rst_half", 1'b0, 32'h0, 32'h0, 32'h0);

    // Cell still works after reset.
    step(1'b0, 1'b1, 32'hF0, 1'b0);
    step(1'b0, 1'b1, 32'h3C, 1'b0);
    expect_all("post_rst", 1'b1, 32'h30, 32'hF0, 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
